// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART receive and transmit sides.
//   DEFAULT_CLK_HZ / DEFAULT_BAUD : default system clock and line rate.
//   rx_state_e                    : receive FSM state encoding.
package uart_pkg;

  localparam int DEFAULT_CLK_HZ = 50_000_000;
  localparam int DEFAULT_BAUD   = 115_200;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_byte_rx_if.sv
// uart_byte_rx_if -- bundle of the serial line plus the receive-FIFO read port.
//   rx        : serial line into the receiver (idle high)
//   rd_en     : pop request for the head byte
//   rd_data   : head byte, show-ahead
//   empty     : no byte available
//   full      : FIFO holds DEPTH bytes
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, good byte dropped because FIFO full
//
// Read handshake: empty low acts as "valid" and rd_en as "ready"; a byte
// transfers on every rising clock edge where rd_en is high and empty is low.
// rd_data is stable while empty is low and no pop happens, and shows the next
// byte on the cycle after a pop. rd_en while empty is ignored.
interface uart_byte_rx_if;
  logic       rx;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic       frame_err;
  logic       overrun;

  // master: drives the line and consumes bytes
  modport master (
    output rx, rd_en,
    input  rd_data, empty, full, frame_err, overrun
  );

  // slave: the receiver itself
  modport slave (
    input  rx, rd_en,
    output rd_data, empty, full, frame_err, overrun
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock show-ahead FIFO.
//   clk, rst    : clock, asynchronous active-high reset
//   wr_en_i     : push request; accepted when writable_o is high
//   wr_data_i   : data to push
//   rd_en_i     : pop request; ignored while empty
//   rd_data_o   : head entry (0 while empty)
//   empty_o     : no entries
//   full_o      : DEPTH entries
//   writable_o  : a push this cycle will be accepted (not full, or full with a pop)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             writable_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  logic pop_d;
  logic push_d;

  // A pop on an empty FIFO is dropped, so a simultaneous push/pop on empty
  // degenerates into a plain push.
  assign pop_d      = rd_en_i && (count_q != '0);
  assign writable_o = (count_q != COUNT_FULL) || pop_d;
  assign push_d     = wr_en_i && writable_o;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == COUNT_FULL);
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Storage is not reset; the output mux hides stale contents while empty.
  always_ff @(posedge clk) begin
    if (push_d) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers are AW bits wide and DEPTH is a power of two, so they wrap
  // modulo DEPTH naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_d) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_d)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_d, pop_d})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx -- 8N1 UART receiver with a small receive FIFO.
//   clk, rst    : sole clock (rising edge), asynchronous active-high reset
//   rx          : asynchronous serial line, idle high
//   rd_en       : pop the head byte
//   rd_data     : head byte (show-ahead), 0 while empty
//   empty, full : FIFO status
//   frame_err   : one-cycle pulse when a stop bit is sampled low
//   overrun     : one-cycle pulse when a good byte is dropped (FIFO full)
//   dbg_state_o : current receive FSM state
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = DEFAULT_CLK_HZ,
  parameter int BAUD   = DEFAULT_BAUD,
  parameter int DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       frame_err,
  output logic       overrun,
  output rx_state_e  dbg_state_o
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNTW         = $clog2(CLKS_PER_BIT);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] CNT_HALF = CNTW'(CLKS_PER_BIT / 2 - 1);

  logic            rx_meta_q;
  logic            rx_s_q;
  logic            rx_prev_q;
  rx_state_e       state_q;
  logic [CNTW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            frame_err_q;
  logic            overrun_q;

  logic stop_tick_d;
  logic push_d;
  logic fifo_writable;

  // The byte is handed to the FIFO combinationally on the stop-sample cycle,
  // so empty drops on the very next cycle.
  assign stop_tick_d = (state_q == RX_STOP) && (cnt_q == CNT_FULL);
  assign push_d      = stop_tick_d && rx_s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      rx_prev_q   <= rx_s_q;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      case (state_q)
        RX_IDLE: begin
          // Edge-triggered: a line stuck low cannot start a second frame.
          if (rx_prev_q && !rx_s_q) begin
            state_q <= RX_START;
            cnt_q   <= '0;
          end
        end

        RX_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            if (!rx_s_q) begin
              state_q   <= RX_DATA;
              bit_idx_q <= '0;
            end else begin
              state_q <= RX_IDLE;  // glitch, silently dropped
            end
          end else begin
            cnt_q <= cnt_q + CNTW'(1);
          end
        end

        RX_DATA: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};  // LSB arrives first
            if (bit_idx_q == 3'd7) begin
              state_q <= RX_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNTW'(1);
          end
        end

        RX_STOP: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            if (!rx_s_q) begin
              frame_err_q <= 1'b1;
            end else if (!fifo_writable) begin
              overrun_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNTW'(1);
          end
        end

        default: begin
          state_q <= RX_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (push_d),
    .wr_data_i  (shift_q),
    .rd_en_i    (rd_en),
    .rd_data_o  (rd_data),
    .empty_o    (empty),
    .full_o     (full),
    .writable_o (fifo_writable)
  );

  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx -- self-checking bench for uart_byte_rx at 16 clocks per bit.
module tb_uart_byte_rx;
  import uart_pkg::*;

  localparam int CLK_HZ   = 16;
  localparam int BAUD     = 1;
  localparam int DEPTH    = 4;
  localparam int BIT_CLKS = CLK_HZ / BAUD;

  // ---------------- clock / reset ----------------
  logic      clk = 1'b0;
  logic      rst = 1'b1;
  rx_state_e dbg_state;

  uart_byte_rx_if u_if ();

  always #5 clk = ~clk;

  uart_byte_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (u_if.rx),
    .rd_en       (u_if.rd_en),
    .rd_data     (u_if.rd_data),
    .empty       (u_if.empty),
    .full        (u_if.full),
    .frame_err   (u_if.frame_err),
    .overrun     (u_if.overrun),
    .dbg_state_o (dbg_state)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  // Pulse monitor: counts flag pulses and any pulse longer than one cycle.
  int   ferr_cnt    = 0;
  int   ovr_cnt     = 0;
  int   long_pulses = 0;
  logic ferr_d      = 1'b0;
  logic ovr_d       = 1'b0;

  always @(negedge clk) begin
    if (u_if.frame_err) ferr_cnt++;
    if (u_if.overrun)   ovr_cnt++;
    if ((u_if.frame_err && ferr_d) || (u_if.overrun && ovr_d)) long_pulses++;
    ferr_d = u_if.frame_err;
    ovr_d  = u_if.overrun;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  int   frame_clk;
  int   fall_idx;
  logic last_empty;

  task automatic tick();
    @(negedge clk);
    frame_clk++;
    if (last_empty && !u_if.empty && fall_idx < 0) fall_idx = frame_clk;
    last_empty = u_if.empty;
  endtask

  // Start bit, 8 data bits LSB first, stop bit, short idle gap.
  task automatic send_byte(input logic [7:0] d, input logic stop);
    frame_clk  = 0;
    fall_idx   = -1;
    last_empty = u_if.empty;
    u_if.rx = 1'b0;
    repeat (BIT_CLKS) tick();
    for (int i = 0; i < 8; i++) begin
      u_if.rx = d[i];
      repeat (BIT_CLKS) tick();
    end
    u_if.rx = stop;
    repeat (BIT_CLKS) tick();
    u_if.rx = 1'b1;
    repeat (4) tick();
  endtask

  task automatic do_pop(input string name, input logic [7:0] exp);
    check({name, " not_empty"}, {31'd0, u_if.empty}, 32'd0);
    check({name, " rd_data"}, {24'd0, u_if.rd_data}, {24'd0, exp});
    u_if.rd_en = 1'b1;
    @(negedge clk);
    u_if.rd_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " empty"},     {31'd0, u_if.empty},     32'd1);
    check({name, " full"},      {31'd0, u_if.full},      32'd0);
    check({name, " frame_err"}, {31'd0, u_if.frame_err}, 32'd0);
    check({name, " overrun"},   {31'd0, u_if.overrun},   32'd0);
    check({name, " rd_data"},   {24'd0, u_if.rd_data},   32'd0);
    check({name, " state"},     {30'd0, dbg_state},      {30'd0, RX_IDLE});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_ferr;
    int         exp_ovr;
    logic       exp_empty;
    logic       exp_full;
    logic [7:0] exp_head;
    logic       pop;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int f0, o0;

    vecs[0] = '{8'h3C, 1'b0, 1, 0, 1'b1, 1'b0, 8'h00, 1'b0};  // bad stop
    vecs[1] = '{8'h7E, 1'b1, 0, 0, 1'b0, 1'b0, 8'h7E, 1'b1};  // recovers
    vecs[2] = '{8'h01, 1'b1, 0, 0, 1'b0, 1'b0, 8'h01, 1'b0};
    vecs[3] = '{8'h02, 1'b1, 0, 0, 1'b0, 1'b0, 8'h01, 1'b0};
    vecs[4] = '{8'h03, 1'b1, 0, 0, 1'b0, 1'b0, 8'h01, 1'b0};
    vecs[5] = '{8'h04, 1'b1, 0, 0, 1'b0, 1'b1, 8'h01, 1'b0};  // now full
    vecs[6] = '{8'h05, 1'b1, 0, 1, 1'b0, 1'b1, 8'h01, 1'b0};  // dropped

    u_if.rx    = 1'b1;
    u_if.rd_en = 1'b0;
    rst        = 1'b1;
    #1;
    check_reset_outputs("reset_init");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte; empty must drop near the middle of the stop bit
    // (nominal sample point 152 clocks in, plus synchronizer latency).
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_byte(8'h55, 1'b1);
    check("b55 fall_lo", {31'd0, (fall_idx >= 153)}, 32'd1);
    check("b55 fall_hi", {31'd0, (fall_idx <= 157)}, 32'd1);
    check("b55 ferr", ferr_cnt - f0, 0);
    check("b55 ovr",  ovr_cnt - o0, 0);
    do_pop("b55", 8'h55);
    check("b55 empty_after", {31'd0, u_if.empty}, 32'd1);

    // Table: frame error recovery, then fill to full and overrun.
    for (int i = 0; i < 7; i++) begin
      f0 = ferr_cnt; o0 = ovr_cnt;
      send_byte(vecs[i].data, vecs[i].stop);
      check($sformatf("v%0d ferr", i),  ferr_cnt - f0, vecs[i].exp_ferr);
      check($sformatf("v%0d ovr", i),   ovr_cnt - o0,  vecs[i].exp_ovr);
      check($sformatf("v%0d empty", i), {31'd0, u_if.empty}, {31'd0, vecs[i].exp_empty});
      check($sformatf("v%0d full", i),  {31'd0, u_if.full},  {31'd0, vecs[i].exp_full});
      if (!vecs[i].exp_empty)
        check($sformatf("v%0d head", i), {24'd0, u_if.rd_data}, {24'd0, vecs[i].exp_head});
      if (vecs[i].pop) do_pop($sformatf("v%0d pop", i), vecs[i].exp_head);
    end
    for (int i = 1; i <= 4; i++) do_pop($sformatf("drain%0d", i), 8'(i));
    check("drain empty", {31'd0, u_if.empty}, 32'd1);
    check("drain full",  {31'd0, u_if.full},  32'd0);

    // rd_en on an empty FIFO is ignored.
    u_if.rd_en = 1'b1;
    repeat (2) @(negedge clk);
    u_if.rd_en = 1'b0;
    check("pop_empty empty", {31'd0, u_if.empty}, 32'd1);

    // Back-to-back frames read in order.
    send_byte(8'hA3, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    do_pop("b2b0", 8'hA3);
    do_pop("b2b1", 8'h00);
    do_pop("b2b2", 8'hFF);
    check("b2b empty", {31'd0, u_if.empty}, 32'd1);

    // Short low glitch is not a start bit.
    f0 = ferr_cnt; o0 = ovr_cnt;
    u_if.rx = 1'b0;
    repeat (4) @(negedge clk);
    u_if.rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch ferr",  ferr_cnt - f0, 0);
    check("glitch ovr",   ovr_cnt - o0, 0);
    check("glitch empty", {31'd0, u_if.empty}, 32'd1);
    check("glitch state", {30'd0, dbg_state}, {30'd0, RX_IDLE});

    // Reset in the middle of data bit 4, with a byte already queued.
    send_byte(8'h11, 1'b1);
    check("pre_rst empty", {31'd0, u_if.empty}, 32'd0);
    begin
      logic [7:0] d;
      d = 8'h96;
      u_if.rx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        u_if.rx = d[i];
        repeat (BIT_CLKS) @(negedge clk);
      end
      u_if.rx = d[4];
      repeat (BIT_CLKS / 2) @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid");
    repeat (3) @(negedge clk);
    u_if.rx = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_hold");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_byte(8'h69, 1'b1);
    check("post_rst ferr", ferr_cnt - f0, 0);
    check("post_rst ovr",  ovr_cnt - o0, 0);
    do_pop("post_rst", 8'h69);
    check("post_rst empty", {31'd0, u_if.empty}, 32'd1);

    // Randomized frames against a queue model of the receiver.
    exp_q.delete();
    for (int n = 0; n < 14; n++) begin
      logic [7:0] d;
      logic       stop;
      int         e_ferr, e_ovr, nrd;
      d      = 8'($urandom_range(0, 255));
      stop   = ($urandom_range(0, 5) != 0);
      e_ferr = 0;
      e_ovr  = 0;
      if (!stop)                     e_ferr = 1;
      else if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else                           e_ovr = 1;
      f0 = ferr_cnt; o0 = ovr_cnt;
      send_byte(d, stop);
      check($sformatf("rnd%0d ferr", n), ferr_cnt - f0, e_ferr);
      check($sformatf("rnd%0d ovr", n),  ovr_cnt - o0,  e_ovr);
      check($sformatf("rnd%0d empty", n), {31'd0, u_if.empty}, {31'd0, exp_q.size() == 0});
      check($sformatf("rnd%0d full", n),  {31'd0, u_if.full},  {31'd0, exp_q.size() == DEPTH});
      nrd = $urandom_range(0, 2);
      for (int k = 0; k < nrd; k++) begin
        if (exp_q.size() > 0) begin
          do_pop($sformatf("rnd%0d rd%0d", n, k), exp_q.pop_front());
        end else begin
          u_if.rd_en = 1'b1;
          @(negedge clk);
          u_if.rd_en = 1'b0;
          check($sformatf("rnd%0d rd_empty", n), {31'd0, u_if.empty}, 32'd1);
        end
      end
    end
    while (exp_q.size() > 0) do_pop("rnd drain", exp_q.pop_front());
    check("rnd final empty", {31'd0, u_if.empty}, 32'd1);

    check("pulse widths", long_pulses, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200: line bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (434 at defaults), required >= 8.
REQ-003 SHALL have parameter DEPTH, default 4: receive FIFO entries, power of two, 2..16.
REQ-004 SHALL have port clk  input  1  sole clock, rising-edge; one clock, all logic in this domain.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port rx  input  1  asynchronous 8N1 serial line, idle high.
REQ-007 SHALL have port rd_en  input  1  pop request for head FIFO entry.
REQ-008 SHALL have port rd_data  output  8  head FIFO entry (show-ahead).
REQ-009 SHALL have port empty  output  1  FIFO holds no bytes.
REQ-010 SHALL have port full  output  1  FIFO holds DEPTH bytes.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-012 SHALL have port overrun  output  1  one-cycle pulse: valid byte dropped because FIFO full.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer (both flops reset to 1); all decoding uses the synchronized value rx_s.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP with a bit-period counter and a 3-bit bit index.
REQ-015 IDLE SHALL move to START only on a detected rx_s 1->0 transition, clearing the counter; a line held low never re-triggers.
REQ-016 START SHALL sample rx_s when counter = CLKS_PER_BIT/2-1: low -> DATA with counter cleared; high -> IDLE (glitch rejected, no flag).
REQ-017 DATA SHALL sample rx_s each time counter = CLKS_PER_BIT-1, shift LSB-first into an 8-bit register, and enter STOP after bit index 7.
REQ-018 STOP SHALL sample rx_s at counter = CLKS_PER_BIT-1 and then return to IDLE unconditionally.
REQ-019 Stop sample high and FIFO writable SHALL push the byte; empty SHALL deassert on the cycle after the stop sample.
REQ-020 Stop sample high and FIFO not writable SHALL discard the byte and pulse overrun for one cycle; FIFO contents unchanged.
REQ-021 Stop sample low SHALL discard the byte and pulse frame_err for one cycle; no push.
REQ-022 FIFO SHALL be writable when not full, or when full and rd_en asserted in the same cycle (pop and push both occur, count unchanged).
REQ-023 rd_en while empty SHALL be ignored; rd_data SHALL be valid whenever empty is low and advance the cycle after a pop.
REQ-024 FIFO read/write pointers SHALL wrap modulo DEPTH; occupancy count SHALL be $clog2(DEPTH)+1 bits, full = (count = DEPTH).
REQ-025 Simultaneous push and pop on an empty FIFO SHALL not occur (pop ignored, push takes effect).

Reset
REQ-026 Asserting rst SHALL immediately force: FSM IDLE, counters 0, shift register 0, FIFO pointers/count 0, empty 1, full 0, frame_err 0, overrun 0, rd_data 0x00, synchronizer flops 1.
REQ-027 Reset mid-frame SHALL abandon the partial byte; after release, reception resumes only on the next 1->0 edge.

Structure
REQ-028 A shared package uart_pkg SHALL hold the rx FSM state enum and the default CLK_HZ/BAUD constants, reused by the transmit side.
REQ-029 The FIFO SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH); deserializer and FSM stay in uart_byte_rx.

Verification (CLK_HZ=16, BAUD=1, CLKS_PER_BIT=16, DEPTH=4)
REQ-030 Send 0x55 with valid stop -> empty falls the cycle after the stop sample, rd_data=0x55, no flags.
REQ-031 Send 0xA3, 0x00, 0xFF back-to-back, then rd_en x3 -> reads 0xA3, 0x00, 0xFF in order, then empty=1.
REQ-032 Send 5 bytes 0x01..0x05 without reads -> full=1 after 4th, overrun pulses once on 5th, reads return 0x01..0x04.
REQ-033 Send 0x3C with stop bit low -> frame_err single-cycle pulse, empty stays 1; following 0x7E received correctly.
REQ-034 Drive rx low for 4 clocks then high -> no START acceptance, no flags, empty stays 1.
REQ-035 Assert rst during DATA bit 4 of 0x96, release, send 0x69 -> only 0x69 in FIFO, all outputs at reset values during rst.
